// File: rtl/adder_seq_arbiter.sv
// Two-requester round-robin front end feeding one N-bit adder that is reused
// over W cycles to add N*W-bit operands slice by slice, LSB slice first.
module adder_seq_arbiter #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [N*W-1:0] req0_A,
  input  logic [N*W-1:0] req0_B,
  input  logic           req0_Cin,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [N*W-1:0] req1_A,
  input  logic [N*W-1:0] req1_B,
  input  logic           req1_Cin,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [N*W-1:0] rsp_Sum,
  output logic           rsp_Cout,
  output logic [1:0]     dbg_state
);

  localparam int OW = N * W;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OW-1:0]   a_q, a_d;
  logic [OW-1:0]   b_q, b_d;
  logic [OW-1:0]   sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            id_q, id_d;
  logic            last_q, last_d;

  logic            grant;
  logic            accept;
  logic [N-1:0]    a_sl, b_sl, s_sl;
  logic            c_sl;

  // Handshake: a requester is accepted on a rising edge where its valid and
  // ready are both 1; a result is consumed where rsp_valid and rsp_ready are 1.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_q;
    else if (req1_valid)          grant = 1'b1;
  end

  assign accept     = rst_n && (state_q == IDLE) && (grant ? req1_valid : req0_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  // The one shared adder; the carry out of the top bit is kept, not dropped.
  assign a_sl = a_q[cnt_q*N +: N];
  assign b_sl = b_q[cnt_q*N +: N];
  assign {c_sl, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{N{1'b0}}, carry_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    id_d    = id_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = grant ? req1_A : req0_A;
          b_d     = grant ? req1_B : req0_B;
          carry_d = grant ? req1_Cin : req0_Cin;
          id_d    = grant;
          last_d  = grant;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[cnt_q*N +: N] = s_sl;
        carry_d             = c_sl;
        if (cnt_q == CW'(W - 1)) begin
          cout_d  = c_sl;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // last_q resets to 1 so that a tie right after reset goes to requester 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_Sum   = sum_q;
  assign rsp_Cout  = cout_q;
  assign rsp_id    = id_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_adder_seq_arbiter.sv
// Directed bench for adder_seq_arbiter at N=4, W=4 (16-bit operands).
module tb_adder_seq_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_A = '0, req0_B = '0, req1_A = '0, req1_B = '0;
  logic        req0_Cin = 1'b0, req1_Cin = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_id;
  logic [15:0] rsp_Sum;
  logic        rsp_Cout;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  adder_seq_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_A(req0_A), .req0_B(req0_B), .req0_Cin(req0_Cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_A(req1_A), .req1_B(req1_B), .req1_Cin(req1_Cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_Sum(rsp_Sum), .rsp_Cout(rsp_Cout), .dbg_state(dbg_state)
  );

  task automatic set_req(input bit k, input logic v, input logic [15:0] a,
                         input logic [15:0] b, input logic cin);
    if (k == 1'b0) begin
      req0_valid = v; req0_A = a; req0_B = b; req0_Cin = cin;
    end else begin
      req1_valid = v; req1_A = a; req1_B = b; req1_Cin = cin;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready_low: got %b want 00", {req1_ready, req0_ready});
    end
    @(negedge clk); #1;
    n_cmp++;
    if (dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_Cout} !== 3'b000) begin
      n_fail++; $display("FAIL reset_rsp_flags: got %b want 000", {rsp_valid, rsp_id, rsp_Cout});
    end
    n_cmp++;
    if (rsp_Sum !== 16'h0000) begin
      n_fail++; $display("FAIL reset_rsp_sum: got %h want 0000", rsp_Sum);
    end
    n_cmp++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready_held: got %b want 00", {req1_ready, req0_ready});
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_op(input bit k, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [15:0] es, input logic ec,
                         input string name);
    int lat;
    @(negedge clk);
    set_req(k, 1'b1, a, b, cin);
    #1;
    n_cmp++;
    if ({req1_ready, req0_ready} !== (k ? 2'b10 : 2'b01)) begin
      n_fail++; $display("FAIL %s_ready: got %b want %b", name, {req1_ready, req0_ready}, (k ? 2'b10 : 2'b01));
    end
    @(negedge clk);
    set_req(k, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
    #1;
    n_cmp++;
    if (dbg_state !== 2'd1) begin
      n_fail++; $display("FAIL %s_run_state: got %0d want 1", name, dbg_state);
    end
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk); #1;
      lat++;
    end
    n_cmp++;
    if (lat !== 5) begin
      n_fail++; $display("FAIL %s_latency: got %0d want 5", name, lat);
    end
    n_cmp++;
    if (rsp_Sum !== es) begin
      n_fail++; $display("FAIL %s_sum: got %h want %h", name, rsp_Sum, es);
    end
    n_cmp++;
    if ({rsp_Cout, rsp_id} !== {ec, k}) begin
      n_fail++; $display("FAIL %s_cout_id: got %b want %b", name, {rsp_Cout, rsp_id}, {ec, k});
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if ({dbg_state, rsp_valid} !== 3'b000) begin
      n_fail++; $display("FAIL %s_back_idle: got %b want 000", name, {dbg_state, rsp_valid});
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    int   acc_cyc[4];
    logic [3:0] ord;
    int   n;
    n = 0; ord = '0;
    @(negedge clk);
    rst_n = 1'b0;
    set_req(1'b0, 1'b1, 16'h0001, 16'h0002, 1'b0);
    set_req(1'b1, 1'b1, 16'h0100, 16'h0200, 1'b0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if ((req0_ready || req1_ready) && n < 4) begin
        acc_cyc[n] = cyc;
        ord = {ord[2:0], req1_ready};
        n++;
      end
      if (rsp_valid) begin
        n_cmp++;
        if (rsp_Sum !== (rsp_id ? 16'h0300 : 16'h0003)) begin
          n_fail++; $display("FAIL rr_sum: got %h want %h", rsp_Sum, (rsp_id ? 16'h0300 : 16'h0003));
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (n !== 4) begin
      n_fail++; $display("FAIL rr_accept_count: got %0d want 4", n);
    end
    n_cmp++;
    if (ord !== 4'b0101) begin
      n_fail++; $display("FAIL rr_order: got %b want 0101", ord);
    end
    for (int i = 1; i < 4; i++) begin
      n_cmp++;
      if (acc_cyc[i] - acc_cyc[i-1] !== 6) begin
        n_fail++; $display("FAIL rr_spacing_%0d: got %0d want 6", i, acc_cyc[i] - acc_cyc[i-1]);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    set_req(1'b0, 1'b1, 16'h00FF, 16'h0001, 1'b0);
    @(negedge clk);
    set_req(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    #1;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk); #1;
      lat++;
    end
    set_req(1'b1, 1'b1, 16'h1111, 16'h2222, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({rsp_valid, rsp_id, rsp_Cout, rsp_Sum, req1_ready, req0_ready} !== {3'b100, 16'h0100, 2'b00}) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got v=%b id=%b c=%b s=%h rdy=%b want v=1 id=0 c=0 s=0100 rdy=00",
                 i, rsp_valid, rsp_id, rsp_Cout, rsp_Sum, {req1_ready, req0_ready});
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if ({rsp_valid, req1_ready, req0_ready} !== 3'b100) begin
      n_fail++; $display("FAIL bp_handshake_no_accept: got %b want 100", {rsp_valid, req1_ready, req0_ready});
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({dbg_state, rsp_valid, req1_ready} !== 4'b0001) begin
      n_fail++; $display("FAIL bp_release_idle: got %b want 0001", {dbg_state, rsp_valid, req1_ready});
    end
    req1_valid = 1'b0; rsp_ready = 1'b0;
  endtask

  task automatic test_rsp_ready_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rsp_ready = 1'b1;
      #1;
      n_cmp++;
      if ({dbg_state, rsp_valid} !== 3'b000) begin
        n_fail++; $display("FAIL idle_rsp_ready_%0d: got %b want 000", i, {dbg_state, rsp_valid});
      end
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    set_req(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    set_req(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({dbg_state, rsp_valid} !== 3'b000) begin
      n_fail++; $display("FAIL abort_idle: got %b want 000", {dbg_state, rsp_valid});
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_rsp: got %b want 0", seen);
    end
    rsp_ready = 1'b0;
    test_op(1'b1, 16'h0F0F, 16'h0101, 1'b1, 16'h1011, 1'b0, "after_abort");
  endtask

  initial begin
    test_reset();
    test_op(1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "basic");
    test_op(1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, "wrap");
    test_op(1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, "msb_ovf");
    test_op(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, "all_ones");
    test_round_robin();
    test_backpressure();
    test_rsp_ready_idle();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
